mem_access_stage: RTL and testbench
===================================

# mem_access_stage

MEM-stage access unit sitting between the EX/MEM pipeline register and the MEM/WB pipeline register. It takes the registered EX/MEM fields and runs loads and stores against a variable-latency data memory over a req/ack handshake. It stalls the upstream pipeline while an access is in flight and presents the address, read data, destination register and write-back controls that MEM/WB captures. It also detects misaligned word accesses and memory timeouts.

## Interface
Parameters:
- TIMEOUT, 16, maximum cycles to wait for mem_ack before aborting the access (2..255)
- ERR_DATA, 32'h0000_0000, read data substituted on a timed-out load

Ports:
- clk  in  1  pipeline clock; all state updates on posedge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  EX/MEM holds a valid instruction
- MemRead, MemWrite  in  1 each  load / store request
- RegWrite, MemToReg  in  1 each  write-back controls, forwarded
- ALUResult  in  32  effective address
- WriteData  in  32  store data
- RdAddr  in  5  destination register
- stall  out  1  hold EX/MEM and earlier stages; MEM/WB must not treat outputs as new
- RegWrite_out, MemToReg_out  out  1 each  to MEM/WB
- MemAddr_out  out  32  to MEM/WB (ALU result passthrough)
- MemReadData_out  out  32  to MEM/WB
- RdAddr_out  out  5  to MEM/WB
- mem_req  out  1  memory request, registered
- mem_we  out  1  1 = store
- mem_addr  out  32  word address (byte address, [1:0] = 0)
- mem_wdata  out  32  store data
- mem_rdata  in  32  load data, valid with mem_ack
- mem_ack  in  1  single-cycle completion pulse
- misalign_err  out  1  one-cycle pulse
- timeout_err  out  1  one-cycle pulse

## Operation
- Access = in_valid & (MemRead | MemWrite). MemRead and MemWrite both set is treated as a load.
- States are IDLE, BUSY and DONE.
- **IDLE**
  - Non-access: outputs are a combinational passthrough of the inputs, stall = 0, and MemReadData_out = 0.
  - Aligned access (ALUResult[1:0] == 0): latch the address, wdata, we, RegWrite, MemToReg and RdAddr, then go to BUSY. stall = 1 in this cycle.
  - Misaligned access: no memory request is issued. Pulse misalign_err. The passthrough is kept but RegWrite_out is forced to 0. stall = 0.
- **BUSY**
  - mem_req = 1 and stall = 1. mem_addr, mem_we and mem_wdata come from the latched values and are stable for the whole state.
  - A wait counter increments every cycle.
  - On mem_ack: latch mem_rdata (loads only; stores latch 0) and go to DONE.
  - When the counter reaches TIMEOUT with no ack: latch ERR_DATA, force the latched RegWrite to 0, pulse timeout_err and go to DONE.
- **DONE**
  - stall = 0. Outputs come from the latched fields and latched read data.
  - The next state is always IDLE. The upstream stage advances on this edge, so the next instruction is seen in IDLE.
- A mem_ack that arrives in IDLE or DONE is ignored.

## Timing
- Reset (async assert, sync-free release): state = IDLE, counter = 0, mem_req = 0, mem_we = 0, stall = 0, both error pulses = 0. All latched fields are 0, so the passthrough outputs follow the inputs immediately.
- Reset asserted during BUSY abandons the access. mem_req drops immediately and asynchronously.
- Load/store latency: IDLE (1 cycle) + BUSY (N cycles, where ack arrives N cycles after mem_req rises, 1 ≤ N ≤ TIMEOUT) + DONE (1 cycle).
  - The total stall is N+1 cycles.
  - Ack in the first BUSY cycle gives the minimum case: 2 stall-free-output cycles later the result is valid.
- mem_req rises on the edge that enters BUSY and falls on the edge that leaves BUSY.
- Timeout fires on the BUSY cycle where counter == TIMEOUT-1 and no ack is present. If ack coincides with that cycle, ack wins and there is no error.
- Error pulses are registered and are high for exactly one cycle: the DONE cycle for timeout, and the cycle after detection for misalign.

## Structure
- The shared pipeline package holds:
  - the state enum (IDLE/BUSY/DONE)
  - the 32-bit word and 5-bit register-address typedefs
  - a mem_ctrl_t struct {RegWrite, MemToReg, MemRead, MemWrite}
- A sub-module mem_wait_timer (counter, clear, terminal-count compare against TIMEOUT) is natural. The FSM and the latches stay in the top module.

## Test plan
- ALU op (MemRead = MemWrite = 0, ALUResult = 0x40, RdAddr = 5, RegWrite = 1) -> same-cycle passthrough, stall = 0, mem_req never asserted, MemReadData_out = 0.
- Load at 0x100, ack 3 cycles after mem_req rises with rdata = 0xCAFEF00D -> stall high 4 cycles. In DONE: MemReadData_out = 0xCAFEF00D, MemAddr_out = 0x100, RdAddr_out intact.
- Store at 0x204 with data 0x12345678, ack 1 cycle after mem_req rises -> mem_we = 1, mem_wdata = 0x12345678 held stable during BUSY, MemReadData_out = 0 in DONE.
- Load at 0x102 -> misalign_err pulses once, no mem_req, RegWrite_out = 0, stall = 0.
- Load with ack never asserted, TIMEOUT = 16 -> stall for 17 cycles, timeout_err single pulse, MemReadData_out = ERR_DATA, RegWrite_out = 0. A stray late ack is then ignored.
- rst_n low in the 2nd BUSY cycle -> mem_req and stall drop without waiting for the clock. After release the next access starts cleanly from IDLE.

Source files
------------

// File: rtl/mem_access_stage_pkg.sv
// mem_access_stage_pkg : shared MEM-stage types (state, word/register typedefs, control bundle)
// Rev 1.0
`default_nettype none

package mem_access_stage_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  reg_addr_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mem_state_e;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic mem_read;
    logic mem_write;
  } mem_ctrl_t;

  function automatic logic is_word_aligned(input word_t addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_wait_timer.sv
// mem_wait_timer : counts BUSY cycles and flags the last permitted wait cycle
// Rev 1.0
`default_nettype none

module mem_wait_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [7:0] c_tc_value = 8'(TIMEOUT - 1);

  logic [7:0] count_q;

  // Holds at terminal count so a stuck enable can never wrap back to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (en_i && !tc_o) begin
      count_q <= count_q + 8'd1;
    end
  end

  assign tc_o = (count_q == c_tc_value);

endmodule

`default_nettype wire

// File: rtl/mem_access_stage.sv
// mem_access_stage : MEM-stage load/store unit with req/ack memory handshake, stall and error pulses
// Rev 1.0
`default_nettype none

module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        RegWrite,
  input  logic        MemToReg,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  input  logic [4:0]  RdAddr,
  output logic        stall,
  output logic        RegWrite_out,
  output logic        MemToReg_out,
  output logic [31:0] MemAddr_out,
  output logic [31:0] MemReadData_out,
  output logic [4:0]  RdAddr_out,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        misalign_err,
  output logic        timeout_err
);

  mem_state_e state_q;
  word_t      addr_q;
  word_t      wdata_q;
  word_t      rdata_q;
  reg_addr_t  rd_q;
  mem_ctrl_t  ctrl_q;
  logic       req_q;
  logic       timeout_err_q;
  logic       misalign_err_q;

  logic w_access;
  logic w_start;
  logic w_misalign;
  logic w_tc;
  logic w_stall;

  assign w_access   = in_valid & (MemRead | MemWrite);
  assign w_start    = (state_q == ST_IDLE) && w_access && is_word_aligned(ALUResult);
  assign w_misalign = (state_q == ST_IDLE) && w_access && !is_word_aligned(ALUResult);

  mem_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (state_q != ST_BUSY),
    .en_i    (state_q == ST_BUSY),
    .tc_o    (w_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      addr_q         <= '0;
      wdata_q        <= '0;
      rdata_q        <= '0;
      rd_q           <= '0;
      ctrl_q         <= '0;
      req_q          <= 1'b0;
      timeout_err_q  <= 1'b0;
      misalign_err_q <= 1'b0;
    end else begin
      misalign_err_q <= w_misalign;
      timeout_err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (w_start) begin
            addr_q  <= ALUResult;
            wdata_q <= WriteData;
            rd_q    <= RdAddr;
            // A request with both MemRead and MemWrite set is a load.
            ctrl_q  <= '{reg_write:  RegWrite,
                         mem_to_reg: MemToReg,
                         mem_read:   MemRead,
                         mem_write:  MemWrite & ~MemRead};
            req_q   <= 1'b1;
            state_q <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (mem_ack) begin
            rdata_q <= ctrl_q.mem_read ? mem_rdata : '0;
            req_q   <= 1'b0;
            state_q <= ST_DONE;
          end else if (w_tc) begin
            rdata_q          <= ERR_DATA;
            ctrl_q.reg_write <= 1'b0;
            timeout_err_q    <= 1'b1;
            req_q            <= 1'b0;
            state_q          <= ST_DONE;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_stall         = 1'b0;
    RegWrite_out    = RegWrite;
    MemToReg_out    = MemToReg;
    MemAddr_out     = ALUResult;
    MemReadData_out = '0;
    RdAddr_out      = RdAddr;
    case (state_q)
      ST_IDLE: begin
        w_stall = w_start;
        if (w_misalign) begin
          RegWrite_out = 1'b0;
        end
      end
      ST_BUSY, ST_DONE: begin
        w_stall         = (state_q == ST_BUSY);
        RegWrite_out    = ctrl_q.reg_write;
        MemToReg_out    = ctrl_q.mem_to_reg;
        MemAddr_out     = addr_q;
        MemReadData_out = rdata_q;
        RdAddr_out      = rd_q;
      end
      default: ;
    endcase
  end

  // Reset must release the pipeline at once even if EX/MEM still presents an access.
  assign stall        = w_stall & rst_n;
  assign mem_req      = req_q;
  assign mem_we       = ctrl_q.mem_write;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign misalign_err = misalign_err_q;
  assign timeout_err  = timeout_err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage : randomized self-checking bench for mem_access_stage against a transaction-level model
// Rev 1.0
`default_nettype none

module tb_mem_access_stage;
  import mem_access_stage_pkg::*;

  localparam int unsigned TIMEOUT  = 16;
  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, MemRead, MemWrite, RegWrite, MemToReg;
  logic [31:0] ALUResult, WriteData;
  logic [4:0]  RdAddr;
  logic        stall, RegWrite_out, MemToReg_out;
  logic [31:0] MemAddr_out, MemReadData_out;
  logic [4:0]  RdAddr_out;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;
  logic        misalign_err, timeout_err;

  int n_checks = 0;
  int n_errors = 0;

  mem_access_stage #(
    .TIMEOUT  (TIMEOUT),
    .ERR_DATA (ERR_DATA)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .MemRead         (MemRead),
    .MemWrite        (MemWrite),
    .RegWrite        (RegWrite),
    .MemToReg        (MemToReg),
    .ALUResult       (ALUResult),
    .WriteData       (WriteData),
    .RdAddr          (RdAddr),
    .stall           (stall),
    .RegWrite_out    (RegWrite_out),
    .MemToReg_out    (MemToReg_out),
    .MemAddr_out     (MemAddr_out),
    .MemReadData_out (MemReadData_out),
    .RdAddr_out      (RdAddr_out),
    .mem_req         (mem_req),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_ack         (mem_ack),
    .misalign_err    (misalign_err),
    .timeout_err     (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive_idle();
    in_valid = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
  endtask

  // One instruction through the stage. lat = cycle of BUSY on which ack is given (0 = never).
  task automatic run_op(input logic vld, input logic rd, input logic wr, input logic rw,
                        input logic m2r, input word_t addr, input word_t wdata,
                        input reg_addr_t rdst, input int lat, input word_t rdata);
    logic  access, mis, timed_out;
    int    nbusy;
    word_t exp_rd;
    access    = vld && (rd || wr);
    mis       = access && (addr[1:0] != 2'b00);
    timed_out = (lat < 1) || (lat > int'(TIMEOUT));
    nbusy     = timed_out ? int'(TIMEOUT) : lat;

    @(posedge clk); #1;
    in_valid = vld; MemRead = rd; MemWrite = wr; RegWrite = rw; MemToReg = m2r;
    ALUResult = addr; WriteData = wdata; RdAddr = rdst; mem_ack = 1'b0;
    @(negedge clk);
    check_eq("first_misalign_err", 32'(misalign_err), 32'd0);
    check_eq("first_timeout_err", 32'(timeout_err), 32'd0);
    check_eq("first_mem_req", 32'(mem_req), 32'd0);
    check_eq("first_addr_out", MemAddr_out, addr);
    check_eq("first_rd_out", 32'(RdAddr_out), 32'(rdst));

    if (!access || mis) begin
      check_eq("pt_stall", 32'(stall), 32'd0);
      check_eq("pt_regwrite", 32'(RegWrite_out), 32'(rw && !mis));
      check_eq("pt_memtoreg", 32'(MemToReg_out), 32'(m2r));
      check_eq("pt_rdata", MemReadData_out, 32'd0);
      @(posedge clk); #1;
      drive_idle();
      @(negedge clk);
      check_eq("misalign_pulse", 32'(misalign_err), 32'(mis));
      check_eq("pt_next_req", 32'(mem_req), 32'd0);
      check_eq("pt_next_stall", 32'(stall), 32'd0);
      return;
    end

    check_eq("start_stall", 32'(stall), 32'd1);
    for (int k = 1; k <= nbusy; k++) begin
      @(posedge clk); #1;
      mem_ack   = (k == lat);
      mem_rdata = (k == lat) ? rdata : $urandom;
      @(negedge clk);
      check_eq("busy_stall", 32'(stall), 32'd1);
      check_eq("busy_req", 32'(mem_req), 32'd1);
      check_eq("busy_addr", mem_addr, addr);
      check_eq("busy_we", 32'(mem_we), 32'(wr && !rd));
      check_eq("busy_wdata", mem_wdata, wdata);
      check_eq("busy_timeout_err", 32'(timeout_err), 32'd0);
    end

    // After a timeout a stray ack is raised in DONE and the following idle cycle.
    @(posedge clk); #1;
    mem_ack   = timed_out;
    mem_rdata = $urandom;
    @(negedge clk);
    exp_rd = timed_out ? ERR_DATA : (rd ? rdata : 32'd0);
    check_eq("done_stall", 32'(stall), 32'd0);
    check_eq("done_req", 32'(mem_req), 32'd0);
    check_eq("done_rdata", MemReadData_out, exp_rd);
    check_eq("done_addr", MemAddr_out, addr);
    check_eq("done_rd", 32'(RdAddr_out), 32'(rdst));
    check_eq("done_regwrite", 32'(RegWrite_out), 32'(rw && !timed_out));
    check_eq("done_memtoreg", 32'(MemToReg_out), 32'(m2r));
    check_eq("done_timeout_err", 32'(timeout_err), 32'(timed_out));

    if (timed_out) begin
      @(posedge clk); #1;
      drive_idle();
      @(negedge clk);
      check_eq("stray_ack_req", 32'(mem_req), 32'd0);
      check_eq("stray_ack_stall", 32'(stall), 32'd0);
      check_eq("stray_ack_rdata", MemReadData_out, 32'd0);
      check_eq("stray_ack_timeout_err", 32'(timeout_err), 32'd0);
      mem_ack = 1'b0;
    end
  endtask

  task automatic reset_mid_busy();
    @(posedge clk); #1;
    in_valid = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; RegWrite = 1'b1; MemToReg = 1'b1;
    ALUResult = 32'h0000_0300; WriteData = 32'd0; RdAddr = 5'd12; mem_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_eq("rst_pre_req", 32'(mem_req), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check_eq("rst_async_req", 32'(mem_req), 32'd0);
    check_eq("rst_async_stall", 32'(stall), 32'd0);
    @(negedge clk);
    drive_idle();
    rst_n = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  initial begin
    word_t a, d, r;
    int    kind, lat;

    rst_n = 1'b0;
    in_valid = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; RegWrite = 1'b1; MemToReg = 1'b0;
    ALUResult = 32'h1234_5670; WriteData = 32'h5555_AAAA; RdAddr = 5'd7;
    mem_rdata = 32'd0; mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("reset_stall", 32'(stall), 32'd0);
    check_eq("reset_req", 32'(mem_req), 32'd0);
    check_eq("reset_we", 32'(mem_we), 32'd0);
    check_eq("reset_mem_addr", mem_addr, 32'd0);
    check_eq("reset_misalign_err", 32'(misalign_err), 32'd0);
    check_eq("reset_timeout_err", 32'(timeout_err), 32'd0);
    check_eq("reset_pt_addr", MemAddr_out, 32'h1234_5670);
    check_eq("reset_pt_rdata", MemReadData_out, 32'd0);
    drive_idle();
    rst_n = 1'b1;

    // Directed cases
    run_op(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0040, 32'h0, 5'd5, 0, 32'h0);
    run_op(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0100, 32'h0, 5'd9, 3, 32'hCAFE_F00D);
    run_op(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0204, 32'h1234_5678, 5'd0, 1, 32'hFFFF_FFFF);
    run_op(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0102, 32'h0, 5'd3, 1, 32'h0);
    run_op(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0400, 32'h0, 5'd17, 0, 32'h0);
    run_op(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0408, 32'h0, 5'd18, int'(TIMEOUT), 32'hA5A5_5A5A);
    run_op(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0500, 32'h7777_7777, 5'd21, 2, 32'h0BAD_CAFE);
    run_op(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0601, 32'h0, 5'd22, 1, 32'h0);
    reset_mid_busy();
    run_op(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0300, 32'h0, 5'd12, 2, 32'h1357_9BDF);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 4);
      a = $urandom;
      d = $urandom;
      r = $urandom;
      lat = $urandom_range(1, TIMEOUT);
      case (kind)
        0: run_op(1'b1, 1'b0, 1'b0, 1'($urandom), 1'($urandom), a, d, 5'($urandom), lat, r);
        1: run_op(1'b1, 1'b1, 1'($urandom), 1'($urandom), 1'($urandom), a & ~32'd3, d, 5'($urandom), lat, r);
        2: run_op(1'b1, 1'b0, 1'b1, 1'($urandom), 1'($urandom), a & ~32'd3, d, 5'($urandom), lat, r);
        3: run_op(1'b1, 1'($urandom), 1'b1, 1'($urandom), 1'($urandom),
                  (a & ~32'd3) | 32'($urandom_range(1, 3)), d, 5'($urandom), lat, r);
        default: run_op(1'b1, 1'b1, 1'b0, 1'($urandom), 1'($urandom), a & ~32'd3, d, 5'($urandom), 0, r);
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
